// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential 8/4 divider.
interface div_seq_if;
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic          start;
  logic [DW-1:0] A;
  logic [VW-1:0] B;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          ready;
  logic          err;

  modport master (output start, A, B, input Q, R, ready, err);
  modport slave  (input start, A, B, output Q, R, ready, err);
endinterface

// File: rtl/div_seq.sv
// Sequential 8-bit by 4-bit restoring divider, one quotient bit per clock.
// Optional divide-by-zero short-cut enabled by defining DIV_SEQ_ZERO_DETECT_EN.
module div_seq (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned CW = 3;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d;
  logic [VW-1:0] b_q, b_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          ready_q, ready_d;
  logic [VW:0]   pr_c;
  logic [VW-1:0] diff_c;
  logic          ge_c;
  logic          zero_c;

  // Partial remainder pulls in the next dividend bit, MSB first.
  assign pr_c   = {r_q, a_q[DW-1]};
  assign ge_c   = (pr_c >= {1'b0, b_q});
  assign diff_c = VW'(pr_c - {1'b0, b_q});

`ifdef DIV_SEQ_ZERO_DETECT_EN
  logic err_q, err_d;
  assign zero_c  = (bus.B == '0);
  assign bus.err = err_q;
`else
  assign zero_c  = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.ready = ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    ready_d = ready_q;
`ifdef DIV_SEQ_ZERO_DETECT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (zero_c) begin
            // Zero divisor: answer immediately without entering RUN.
`ifdef DIV_SEQ_ZERO_DETECT_EN
            err_d = 1'b1;
`endif
            q_d = '1;
            r_d = bus.A[VW-1:0];
          end else begin
`ifdef DIV_SEQ_ZERO_DETECT_EN
            err_d = 1'b0;
`endif
            a_d     = bus.A;
            b_d     = bus.B;
            q_d     = '0;
            r_d     = '0;
            cnt_d   = '0;
            ready_d = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        q_d   = {q_q[DW-2:0], ge_c};
        r_d   = ge_c ? diff_c : pr_c[VW-1:0];
        a_d   = {a_q[DW-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ready_q <= 1'b1;
`ifdef DIV_SEQ_ZERO_DETECT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ready_q <= ready_d;
`ifdef DIV_SEQ_ZERO_DETECT_EN
      err_q   <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver queues expected results, monitor checks on ready rise.
module tb_div_seq;
  logic clk;
  logic rst;
  div_seq_if bus ();

  div_seq dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    int         done;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is presented when ready rises outside reset.
  always @(negedge clk) begin
    if (!rst && bus.ready === 1'b1 && prev_ready === 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Q", 32'(bus.Q), 32'(e.q));
        chk("R", 32'(bus.R), 32'(e.r));
        chk("err", 32'(bus.err), 32'd0);
        chk("latency", 32'(cyc), 32'(e.done));
      end
    end
    prev_ready = bus.ready;
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) chk("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  // Issue one request at a negedge; returns at the next negedge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er, input bit hold);
    exp_t e;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
`ifdef DIV_SEQ_ZERO_DETECT_EN
    if (b == 4'd0) begin
      @(negedge clk);
      chk("zero_ready", 32'(bus.ready), 32'd1);
      chk("zero_Q", 32'(bus.Q), 32'(eq));
      chk("zero_R", 32'(bus.R), 32'(er));
      chk("zero_err", 32'(bus.err), 32'd1);
      if (!hold) bus.start = 1'b0;
      return;
    end
`endif
    e.q    = eq;
    e.r    = er;
    e.done = cyc + 9;
    sb.push_back(e);
    @(negedge clk);
    chk("busy", 32'(bus.ready), 32'd0);
    if (!hold) bus.start = 1'b0;
  endtask

  initial begin
    exp_t e;
    bus.start = 1'b1;
    bus.A     = 8'd108;
    bus.B     = 4'd9;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_Q", 32'(bus.Q), 32'd0);
    chk("rst_R", 32'(bus.R), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    // start held during reset must be ignored
    repeat (2) @(negedge clk);
    chk("start_in_rst", 32'(bus.ready), 32'd1);

    // first start accepted on the first edge after reset release: 108/9
    #2 rst = 1'b0;
    e.q = 8'd12; e.r = 4'd0; e.done = cyc + 9;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_first", 32'(bus.ready), 32'd0);
    wait_ready();

    // back-to-back with start held high
    issue(8'd200, 4'd7,  8'd28,  4'd4, 1'b1);
    wait_ready();
    issue(8'd255, 4'd1,  8'd255, 4'd0, 1'b1);
    wait_ready();
    issue(8'd0,   4'd5,  8'd0,   4'd0, 1'b1);
    wait_ready();
    issue(8'd3,   4'd15, 8'd0,   4'd3, 1'b0);
    wait_ready();
    issue(8'd254, 4'd3,  8'd84,  4'd2, 1'b0);
    wait_ready();
    issue(8'd255, 4'd15, 8'd17,  4'd0, 1'b0);
    wait_ready();

    // start while running is ignored
    issue(8'd100, 4'd10, 8'd10, 4'd0, 1'b0);
    @(negedge clk);
    bus.A = 8'd50; bus.B = 4'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 8'd0; bus.B = 4'd0;
    wait_ready();

    // reset mid-operation aborts with no result
    issue(8'd77, 4'd6, 8'd12, 4'd5, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_Q", 32'(bus.Q), 32'd0);
    chk("abort_R", 32'(bus.R), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(8'd77, 4'd6, 8'd12, 4'd5, 1'b0);
    wait_ready();

    // zero divisor
    issue(8'h5A, 4'd0, 8'hFF, 4'hA, 1'b0);
    wait_ready();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
endmodule
